// File: rtl/issue_scoreboard_m1_pkg.sv
// Shared issue-stage types: decoded uOP bundle, issue FSM states and
// register-file sizing.
package Types_m1;

    localparam int NUM_ARCH_REGS = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HELD  = 2'd1,
        FENCE = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic [7:0] opcode;
        logic       fence_mode;
        logic       rs1_dependency;
        logic       rs2_dependency;
        logic       regfile_write;
        logic       call_alu;
        logic       call_mul;
        logic       call_div;
        logic       call_lsu;
        logic       call_brh;
    } uop_t;

    function automatic logic uop_is_nop(uop_t u);
        return !(u.call_alu | u.call_mul | u.call_div | u.call_lsu | u.call_brh);
    endfunction

endpackage

// File: rtl/issue_scoreboard_m1_scoreboard.sv
// Busy-bit array: one set port, two writeback clear ports, set wins.
// Also exports the bypassed view with this cycle's clears applied.
module scoreboard_m1
    import Types_m1::*;
#(
    parameter int NUM_REGS  = NUM_ARCH_REGS,
    parameter int REG_IDX_W = $clog2(NUM_REGS)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 set_valid_in,
    input  logic [REG_IDX_W-1:0] set_rd_in,
    input  logic                 clr0_valid_in,
    input  logic [REG_IDX_W-1:0] clr0_rd_in,
    input  logic                 clr1_valid_in,
    input  logic [REG_IDX_W-1:0] clr1_rd_in,
    output logic [NUM_REGS-1:0]  busy_out,
    output logic [NUM_REGS-1:0]  eff_busy_out
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] set_mask, clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_valid_in) set_mask[set_rd_in] = 1'b1;
        if (clr0_valid_in) clr_mask[clr0_rd_in] = 1'b1;
        if (clr1_valid_in) clr_mask[clr1_rd_in] = 1'b1;
        // r0 is hardwired zero and can never be tracked
        set_mask[0] = 1'b0;
        clr_mask[0] = 1'b0;
        eff_busy_out = busy_q & ~clr_mask;
        busy_d = eff_busy_out | set_mask;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_out = busy_q;

endmodule

// File: rtl/issue_scoreboard_m1.sv
// Single-entry issue stage with busy-bit hazard check and fence drain.
// Optional ISSUE_STATS_EN adds saturating stall/fence cycle counters.
module issue_scoreboard_m1
    import Types_m1::*;
#(
    parameter int NUM_REGS  = NUM_ARCH_REGS,
    parameter int REG_IDX_W = $clog2(NUM_REGS)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 dec_valid_in,
    output logic                 dec_ready_out,
    input  uop_t                 dec_uop_in,
    input  logic [REG_IDX_W-1:0] dec_rd_in,
    input  logic [REG_IDX_W-1:0] dec_rs1_in,
    input  logic [REG_IDX_W-1:0] dec_rs2_in,
    input  logic                 flush_in,
    output uop_t                 iss_uop_out,
    output logic [REG_IDX_W-1:0] iss_rd_out,
    output logic [REG_IDX_W-1:0] iss_rs1_out,
    output logic [REG_IDX_W-1:0] iss_rs2_out,
    output logic                 alu_valid_out,
    output logic                 mul_valid_out,
    output logic                 div_valid_out,
    output logic                 lsu_valid_out,
    output logic                 brh_valid_out,
    input  logic                 alu_ready_in,
    input  logic                 mul_ready_in,
    input  logic                 div_ready_in,
    input  logic                 lsu_ready_in,
    input  logic                 brh_ready_in,
    input  logic                 lsu_idle_in,
    input  logic                 wb0_valid_in,
    input  logic [REG_IDX_W-1:0] wb0_rd_in,
    input  logic                 wb1_valid_in,
    input  logic [REG_IDX_W-1:0] wb1_rd_in,
    output logic [NUM_REGS-1:0]  busy_out
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0]          stat_hazard_cycles_out,
    output logic [31:0]          stat_unit_stall_cycles_out,
    output logic [31:0]          stat_fence_cycles_out
`endif
);

    issue_state_t         state_q, state_d;
    uop_t                 uop_q, uop_d;
    logic [REG_IDX_W-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [NUM_REGS-1:0]  eff_busy;
    logic                 hazard, held_ok, target_rdy;
    logic                 fire, fence_done, accept;

    scoreboard_m1 #(
        .NUM_REGS (NUM_REGS),
        .REG_IDX_W(REG_IDX_W)
    ) u_sb (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .set_valid_in (fire && uop_q.regfile_write),
        .set_rd_in    (rd_q),
        .clr0_valid_in(wb0_valid_in),
        .clr0_rd_in   (wb0_rd_in),
        .clr1_valid_in(wb1_valid_in),
        .clr1_rd_in   (wb1_rd_in),
        .busy_out     (busy_out),
        .eff_busy_out (eff_busy)
    );

    always_comb begin
        hazard = 1'b0;
        if (uop_q.rs1_dependency && rs1_q != '0 && eff_busy[rs1_q]) hazard = 1'b1;
        if (uop_q.rs2_dependency && rs2_q != '0 && eff_busy[rs2_q]) hazard = 1'b1;
        if (uop_q.regfile_write && rd_q != '0 && eff_busy[rd_q]) hazard = 1'b1;
    end

    // Strobes are masked in flush/reset cycles so no unit sees a dead uOP.
    assign held_ok = (state_q == HELD) && !hazard && !flush_in && !rst_in;
    assign alu_valid_out = held_ok && uop_q.call_alu;
    assign mul_valid_out = held_ok && uop_q.call_mul;
    assign div_valid_out = held_ok && uop_q.call_div;
    assign lsu_valid_out = held_ok && uop_q.call_lsu;
    assign brh_valid_out = held_ok && uop_q.call_brh;

    assign target_rdy = (uop_q.call_alu && alu_ready_in)
                      | (uop_q.call_mul && mul_ready_in)
                      | (uop_q.call_div && div_ready_in)
                      | (uop_q.call_lsu && lsu_ready_in)
                      | (uop_q.call_brh && brh_ready_in)
                      | uop_is_nop(uop_q);

    assign fire = held_ok && target_rdy;
    assign fence_done = (state_q == FENCE) && (eff_busy == '0) && lsu_idle_in
                      && !flush_in && !rst_in;
    assign dec_ready_out = !flush_in && ((state_q == EMPTY) || fire || fence_done);
    assign accept = dec_valid_in && dec_ready_out;

    always_comb begin
        state_d = state_q;
        uop_d   = uop_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        if (fire || fence_done) state_d = EMPTY;
        if (accept) begin
            state_d = dec_uop_in.fence_mode ? FENCE : HELD;
            uop_d   = dec_uop_in;
            rd_d    = dec_rd_in;
            rs1_d   = dec_rs1_in;
            rs2_d   = dec_rs2_in;
        end
        if (flush_in) state_d = EMPTY;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= EMPTY;
            uop_q   <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else begin
            state_q <= state_d;
            uop_q   <= uop_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
        end
    end

    assign iss_uop_out = uop_q;
    assign iss_rd_out  = rd_q;
    assign iss_rs1_out = rs1_q;
    assign iss_rs2_out = rs2_q;

`ifdef ISSUE_STATS_EN
    logic [31:0] hz_cnt_q, hz_cnt_d;
    logic [31:0] us_cnt_q, us_cnt_d;
    logic [31:0] fc_cnt_q, fc_cnt_d;

    always_comb begin
        hz_cnt_d = hz_cnt_q;
        us_cnt_d = us_cnt_q;
        fc_cnt_d = fc_cnt_q;
        if (state_q == HELD && hazard && hz_cnt_q != '1)
            hz_cnt_d = hz_cnt_q + 32'd1;
        if (state_q == HELD && !hazard && !target_rdy && us_cnt_q != '1)
            us_cnt_d = us_cnt_q + 32'd1;
        if (state_q == FENCE && fc_cnt_q != '1)
            fc_cnt_d = fc_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hz_cnt_q <= '0;
            us_cnt_q <= '0;
            fc_cnt_q <= '0;
        end else begin
            hz_cnt_q <= hz_cnt_d;
            us_cnt_q <= us_cnt_d;
            fc_cnt_q <= fc_cnt_d;
        end
    end

    assign stat_hazard_cycles_out     = hz_cnt_q;
    assign stat_unit_stall_cycles_out = us_cnt_q;
    assign stat_fence_cycles_out      = fc_cnt_q;
`endif

endmodule

// File: tb/tb_issue_scoreboard_m1.sv
// Randomized + directed bench for issue_scoreboard_m1 with a queue/bitmap
// reference model checked by an independent negedge monitor.
module tb_issue_scoreboard_m1;
    import Types_m1::*;

    localparam int UALU = 0, UMUL = 1, UDIV = 2, ULSU = 3, UBRH = 4;
    localparam int UNOP = 5, UFEN = 6;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       dec_valid_in, dec_ready_out;
    uop_t       dec_uop_in;
    logic [3:0] dec_rd_in, dec_rs1_in, dec_rs2_in;
    logic       flush_in;
    uop_t       iss_uop_out;
    logic [3:0] iss_rd_out, iss_rs1_out, iss_rs2_out;
    logic       alu_valid_out, mul_valid_out, div_valid_out;
    logic       lsu_valid_out, brh_valid_out;
    logic       alu_ready_in, mul_ready_in, div_ready_in;
    logic       lsu_ready_in, brh_ready_in;
    logic       lsu_idle_in;
    logic       wb0_valid_in, wb1_valid_in;
    logic [3:0] wb0_rd_in, wb1_rd_in;
    logic [15:0] busy_out;

    issue_scoreboard_m1 dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .dec_valid_in (dec_valid_in),
        .dec_ready_out(dec_ready_out),
        .dec_uop_in   (dec_uop_in),
        .dec_rd_in    (dec_rd_in),
        .dec_rs1_in   (dec_rs1_in),
        .dec_rs2_in   (dec_rs2_in),
        .flush_in     (flush_in),
        .iss_uop_out  (iss_uop_out),
        .iss_rd_out   (iss_rd_out),
        .iss_rs1_out  (iss_rs1_out),
        .iss_rs2_out  (iss_rs2_out),
        .alu_valid_out(alu_valid_out),
        .mul_valid_out(mul_valid_out),
        .div_valid_out(div_valid_out),
        .lsu_valid_out(lsu_valid_out),
        .brh_valid_out(brh_valid_out),
        .alu_ready_in (alu_ready_in),
        .mul_ready_in (mul_ready_in),
        .div_ready_in (div_ready_in),
        .lsu_ready_in (lsu_ready_in),
        .brh_ready_in (brh_ready_in),
        .lsu_idle_in  (lsu_idle_in),
        .wb0_valid_in (wb0_valid_in),
        .wb0_rd_in    (wb0_rd_in),
        .wb1_valid_in (wb1_valid_in),
        .wb1_rd_in    (wb1_rd_in),
        .busy_out     (busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        uop_t       u;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] mbusy = '0;
    int          checks = 0;
    int          failures = 0;
    logic [4:0]  valids;

    assign valids = {alu_valid_out, mul_valid_out, div_valid_out,
                     lsu_valid_out, brh_valid_out};

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the held uOP is the head of a queue of accepted uOPs;
    // busy is a plain bitmap updated from the rules of hazard/fire/writeback.
    task automatic model_step();
        logic [15:0] clr, eff;
        logic [4:0]  ev, calls, rdy;
        logic        hz, fire, fdone, held, er;
        ent_t        h, e;
        if (rst_in) begin
            chk("rst_no_strobe", valids, 0);
            mq.delete();
            mbusy = '0;
            return;
        end
        clr = '0;
        for (int i = 1; i < 16; i++) begin
            if (wb0_valid_in && wb0_rd_in == i) clr[i] = 1'b1;
            if (wb1_valid_in && wb1_rd_in == i) clr[i] = 1'b1;
        end
        eff = mbusy & ~clr;
        held = mq.size() != 0;
        ev = '0; fire = 0; fdone = 0; hz = 0; h = '0;
        if (held) begin
            h = mq[0];
            chk("iss_fields", {iss_uop_out, iss_rd_out, iss_rs1_out, iss_rs2_out},
                {h.u, h.rd, h.rs1, h.rs2});
            calls = {h.u.call_alu, h.u.call_mul, h.u.call_div,
                     h.u.call_lsu, h.u.call_brh};
            rdy = {alu_ready_in, mul_ready_in, div_ready_in,
                   lsu_ready_in, brh_ready_in};
            if (h.u.fence_mode) begin
                fdone = !flush_in && eff == 0 && lsu_idle_in;
            end else begin
                hz = (h.u.rs1_dependency && h.rs1 != 0 && eff[h.rs1])
                  || (h.u.rs2_dependency && h.rs2 != 0 && eff[h.rs2])
                  || (h.u.regfile_write && h.rd != 0 && eff[h.rd]);
                if (!hz && !flush_in) begin
                    ev = calls;
                    fire = (calls == 0) || ((calls & rdy) != 0);
                end
            end
        end
        er = !flush_in && (!held || fire || fdone);
        chk("unit_valid", valids, ev);
        chk("dec_ready", dec_ready_out, er);
        chk("busy", busy_out, mbusy);
        mbusy = eff;
        if (fire && h.u.regfile_write && h.rd != 0) mbusy[h.rd] = 1'b1;
        if (held && (fire || fdone || flush_in)) void'(mq.pop_front());
        if (dec_valid_in && er) begin
            e.u = dec_uop_in; e.rd = dec_rd_in;
            e.rs1 = dec_rs1_in; e.rs2 = dec_rs2_in;
            mq.push_back(e);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_in);
            model_step();
        end
    end

    function automatic uop_t mk(input int unit, input bit wr,
                                input bit d1, input bit d2);
        uop_t u;
        u = '0;
        u.opcode = 8'(unit * 17 + 3);
        u.regfile_write = wr;
        u.rs1_dependency = d1;
        u.rs2_dependency = d2;
        case (unit)
            UALU: u.call_alu = 1'b1;
            UMUL: u.call_mul = 1'b1;
            UDIV: u.call_div = 1'b1;
            ULSU: u.call_lsu = 1'b1;
            UBRH: u.call_brh = 1'b1;
            UFEN: begin u.fence_mode = 1'b1; u.regfile_write = 1'b0;
                        u.rs1_dependency = 1'b0; u.rs2_dependency = 1'b0; end
            default: ;
        endcase
        return u;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic quiet();
        dec_valid_in = 0; dec_uop_in = '0;
        dec_rd_in = 0; dec_rs1_in = 0; dec_rs2_in = 0;
        flush_in = 0; wb0_valid_in = 0; wb1_valid_in = 0;
        wb0_rd_in = 0; wb1_rd_in = 0;
        alu_ready_in = 1; mul_ready_in = 1; div_ready_in = 1;
        lsu_ready_in = 1; brh_ready_in = 1; lsu_idle_in = 1;
    endtask

    task automatic do_reset();
        quiet();
        rst_in = 1;
        step();
        step();
        rst_in = 0;
    endtask

    task automatic send(input uop_t u, input logic [3:0] rd,
                        input logic [3:0] rs1, input logic [3:0] rs2);
        bit ok;
        ok = 0;
        dec_valid_in = 1; dec_uop_in = u;
        dec_rd_in = rd; dec_rs1_in = rs1; dec_rs2_in = rs2;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_in);
            if (dec_ready_out) ok = 1;
            step();
        end
        dec_valid_in = 0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=no_accept required=accept");
        end
    endtask

    task automatic rnd_cycle();
        uop_t u;
        int   k;
        int   bq[$];
        k = $urandom % 10;
        case (k)
            0, 1, 9: u = mk(UALU, $urandom % 2, $urandom % 2, $urandom % 2);
            2: u = mk(UMUL, $urandom % 2, $urandom % 2, $urandom % 2);
            3: u = mk(UDIV, $urandom % 2, $urandom % 2, $urandom % 2);
            4: u = mk(ULSU, $urandom % 2, $urandom % 2, $urandom % 2);
            5: u = mk(UBRH, $urandom % 2, $urandom % 2, $urandom % 2);
            6, 7: u = mk(UNOP, $urandom % 2, $urandom % 2, $urandom % 2);
            default: u = mk(UFEN, 0, 0, 0);
        endcase
        u.opcode = 8'($urandom);
        dec_uop_in = u;
        dec_valid_in = ($urandom % 4) != 0;
        dec_rd_in = 4'($urandom % 8);
        dec_rs1_in = 4'($urandom % 8);
        dec_rs2_in = 4'($urandom % 8);
        alu_ready_in = ($urandom % 4) != 0;
        mul_ready_in = ($urandom % 4) != 0;
        div_ready_in = ($urandom % 4) != 0;
        lsu_ready_in = ($urandom % 4) != 0;
        brh_ready_in = ($urandom % 4) != 0;
        lsu_idle_in = ($urandom % 3) != 0;
        flush_in = ($urandom % 40) == 0;
        for (int i = 1; i < 16; i++) if (mbusy[i]) bq.push_back(i);
        if (bq.size() > 0 && ($urandom % 2) == 1) begin
            wb0_valid_in = 1; wb0_rd_in = 4'(bq[$urandom % bq.size()]);
        end else begin
            wb0_valid_in = ($urandom % 6) == 0; wb0_rd_in = 4'($urandom);
        end
        if (bq.size() > 0 && ($urandom % 3) == 0) begin
            wb1_valid_in = 1; wb1_rd_in = 4'(bq[$urandom % bq.size()]);
        end else begin
            wb1_valid_in = ($urandom % 6) == 0; wb1_rd_in = 4'($urandom);
        end
    endtask

    initial begin
        int n;
        quiet();
        rst_in = 1;
        step();
        step();
        rst_in = 0;
        @(negedge clk_in);
        chk("reset_ready", dec_ready_out, 1);
        chk("reset_busy", busy_out, 0);
        chk("reset_iss", {iss_uop_out, iss_rd_out, iss_rs1_out, iss_rs2_out}, 0);
        chk("reset_valids", valids, 0);
        step();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            rnd_cycle();
            rst_in = (cyc == 1500);
            step();
        end
        rst_in = 0;
        do_reset();

        // RAW: consumer of r3 stalls until the wb0 bypass
        send(mk(UALU, 1, 0, 0), 3, 0, 0);
        send(mk(UALU, 1, 1, 0), 6, 3, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            chk("raw_stall", alu_valid_out, 0);
            step();
        end
        wb0_valid_in = 1; wb0_rd_in = 3;
        @(negedge clk_in);
        chk("raw_bypass_fire", alu_valid_out, 1);
        step();
        wb0_valid_in = 0;
        do_reset();

        // MUL held while unit not ready
        mul_ready_in = 0;
        send(mk(UMUL, 1, 0, 0), 5, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("mul_hold_valid", mul_valid_out, 1);
            chk("mul_hold_ready", dec_ready_out, 0);
            chk("mul_hold_busy", busy_out[5], 0);
            step();
        end
        mul_ready_in = 1;
        @(negedge clk_in);
        chk("mul_handshake", mul_valid_out, 1);
        step();
        @(negedge clk_in);
        chk("mul_busy_set", busy_out[5], 1);
        do_reset();

        // Fence drains busy r2/r7 and waits for LSU idle
        send(mk(UALU, 1, 0, 0), 2, 0, 0);
        send(mk(UALU, 1, 0, 0), 7, 0, 0);
        lsu_idle_in = 0;
        send(mk(UFEN, 0, 0, 0), 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_in);
            chk("fence_no_strobe", valids, 0);
            chk("fence_hold", dec_ready_out, 0);
            step();
        end
        wb0_valid_in = 1; wb0_rd_in = 2;
        wb1_valid_in = 1; wb1_rd_in = 7;
        @(negedge clk_in);
        chk("fence_lsu_busy", dec_ready_out, 0);
        step();
        wb0_valid_in = 0; wb1_valid_in = 0;
        lsu_idle_in = 1;
        @(negedge clk_in);
        chk("fence_retire", dec_ready_out, 1);
        chk("fence_retire_strobe", valids, 0);
        step();
        do_reset();

        // Flush of a hazard-stalled uOP keeps busy intact
        send(mk(UALU, 1, 0, 0), 9, 0, 0);
        send(mk(UALU, 0, 1, 0), 6, 9, 0);
        @(negedge clk_in);
        chk("flush_pre_stall", alu_valid_out, 0);
        step();
        flush_in = 1;
        @(negedge clk_in);
        chk("flush_cycle_ready", dec_ready_out, 0);
        step();
        flush_in = 0;
        @(negedge clk_in);
        chk("flush_empty_ready", dec_ready_out, 1);
        chk("flush_keeps_busy", busy_out[9], 1);
        chk("flush_no_strobe", valids, 0);
        step();
        do_reset();

        // WAW set coinciding with wb1 clear of r4: set wins; r0 never busy
        send(mk(UALU, 1, 0, 0), 4, 0, 0);
        send(mk(UALU, 1, 0, 0), 4, 0, 0);
        @(negedge clk_in);
        chk("waw_stall", alu_valid_out, 0);
        step();
        wb1_valid_in = 1; wb1_rd_in = 4;
        @(negedge clk_in);
        chk("waw_bypass_fire", alu_valid_out, 1);
        step();
        wb1_valid_in = 0;
        @(negedge clk_in);
        chk("set_wins", busy_out[4], 1);
        step();
        send(mk(UALU, 1, 0, 0), 0, 0, 0);
        step();
        @(negedge clk_in);
        chk("r0_never_busy", busy_out[0], 0);
        step();
        do_reset();

        // Back-to-back independent ALU uOPs
        n = 0;
        for (int k = 0; k < 11; k++) begin
            dec_valid_in = (k < 10);
            dec_uop_in = mk(UALU, 0, 0, 0);
            dec_rd_in = 4'(k + 1); dec_rs1_in = 0; dec_rs2_in = 0;
            @(negedge clk_in);
            chk("b2b_ready", dec_ready_out, 1);
            if (alu_valid_out) n++;
            step();
        end
        dec_valid_in = 0;
        chk("b2b_count", n, 10);
        do_reset();

        // Reset mid-operation drops the held uOP with no strobe
        send(mk(UALU, 1, 0, 0), 11, 0, 0);
        send(mk(UALU, 0, 1, 0), 6, 11, 0);
        wb0_valid_in = 1; wb0_rd_in = 11;
        rst_in = 1;
        @(negedge clk_in);
        chk("midrst_no_strobe", valids, 0);
        step();
        rst_in = 0;
        wb0_valid_in = 0;
        @(negedge clk_in);
        chk("midrst_busy", busy_out, 0);
        chk("midrst_ready", dec_ready_out, 1);
        chk("midrst_iss", {iss_uop_out, iss_rd_out, iss_rs1_out, iss_rs2_out}, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
